// File: rtl/pit_counter.sv
// rtl/pit_counter.sv - one 8254-style interval timer channel (16-bit binary/BCD down-counter, modes 0-5)
// Ports:
//   clkinput           rising-edge clock; also the count clock
//   reset              synchronous active-high reset
//   Data               8-bit bidirectional bus; driven only while ReadSignal=1
//   out                counter OUT line
//   WriteSignal        byte on Data written on every rising edge while high
//   ReadSignal         block drives the selected read byte while high
//   gate               GATE input, sampled on clkinput
//   EnableStatusLatch  latch the status byte
//   EnableCounterLatch latch CE into the output latch
//   ControlWord        [5:4] RW, [3:1] mode, [0] BCD
//   ChgControlWord     load ControlWord on this edge
//   CEoutput           live counting-element value
module pit_counter (
    input  logic        clkinput,
    input  logic        reset,
    inout  wire  [7:0]  Data,
    output logic        out,
    input  logic        WriteSignal,
    input  logic        ReadSignal,
    input  logic        gate,
    input  logic        EnableStatusLatch,
    input  logic        EnableCounterLatch,
    input  logic [5:0]  ControlWord,
    input  logic        ChgControlWord,
    output logic [15:0] CEoutput
);

    logic [5:0]  cw;
    logic [15:0] cr, ce, ol;
    logic [7:0]  status;
    logic        ol_full, status_full, null_count;
    logic        wr_msb, rd_msb;
    logic        load_pending, have_count, running;
    logic        gate_d, gate_rise, read_d;
    logic        extra;   // mode 3: one extra high clock for odd counts
    logic        armed;   // modes 4/5: strobe not yet issued for this load

    logic [1:0]  rw;
    logic [2:0]  mode;
    logic        bcd;
    logic [15:0] n1, n2, cr_even, src;
    logic [7:0]  read_byte;
    logic        cw_load, latch_cmd, wr_en, rd_done;

    function automatic logic [15:0] dec1(input logic [15:0] v, input logic b);
        logic [15:0] r;
        logic        borrow;
        r = v;
        borrow = 1'b1;
        if (!b) begin
            r = v - 16'd1;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (borrow) begin
                    if (v[4*i +: 4] == 4'd0) begin
                        r[4*i +: 4] = 4'd9;
                    end else begin
                        r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                        borrow = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

    assign rw      = cw[5:4];
    // Modes 6 and 7 alias to 2 and 3.
    assign mode    = (cw[3] && cw[2]) ? {1'b0, cw[2:1]} : cw[3:1];
    assign bcd     = cw[0];
    assign n1      = dec1(ce, bcd);
    assign n2      = dec1(n1, bcd);
    assign cr_even = {cr[15:1], 1'b0};

    assign cw_load   = ChgControlWord && (ControlWord[5:4] != 2'b00);
    assign latch_cmd = EnableCounterLatch || (ChgControlWord && (ControlWord[5:4] == 2'b00));
    assign wr_en     = WriteSignal && !ChgControlWord && (rw != 2'b00);
    assign rd_done   = read_d && !ReadSignal;

    assign src = ol_full ? ol : ce;
    always_comb begin
        read_byte = src[7:0];
        if (status_full)        read_byte = status;
        else if (rw == 2'b10)   read_byte = src[15:8];
        else if (rw == 2'b11)   read_byte = rd_msb ? src[15:8] : src[7:0];
    end

    assign Data     = ReadSignal ? read_byte : 8'hzz;
    assign CEoutput = ce;

    always_ff @(posedge clkinput) begin
        if (reset) begin
            cw <= '0; cr <= '0; ce <= '0; ol <= '0; status <= '0;
            ol_full <= 1'b0; status_full <= 1'b0; null_count <= 1'b1;
            wr_msb <= 1'b0; rd_msb <= 1'b0;
            load_pending <= 1'b0; have_count <= 1'b0; running <= 1'b0;
            gate_d <= 1'b0; gate_rise <= 1'b0; read_d <= 1'b0;
            extra <= 1'b0; armed <= 1'b0; out <= 1'b0;
        end else begin
            gate_d    <= gate;
            gate_rise <= gate && !gate_d;
            read_d    <= ReadSignal;

            if (cw_load) begin
                cw <= ControlWord;
                ol_full <= 1'b0; status_full <= 1'b0;
                wr_msb <= 1'b0; rd_msb <= 1'b0;
                null_count <= 1'b1;
                load_pending <= 1'b0; have_count <= 1'b0; running <= 1'b0;
                extra <= 1'b0; armed <= 1'b0;
                out <= (ControlWord[3:1] != 3'd0);
            end else begin
                // Counting element
                case (mode)
                    3'd0: begin
                        if (load_pending) begin
                            ce <= cr; null_count <= 1'b0; load_pending <= 1'b0; running <= 1'b1;
                        end else if (running && gate) begin
                            ce <= n1;
                            if (n1 == 16'd0) out <= 1'b1;
                        end
                    end
                    3'd1: begin
                        if (gate_rise && have_count) begin
                            ce <= cr; out <= 1'b0; null_count <= 1'b0; running <= 1'b1;
                        end else if (running) begin
                            ce <= n1;
                            if (n1 == 16'd0) out <= 1'b1;
                        end
                    end
                    3'd2: begin
                        if (!gate) begin
                            out <= 1'b1;
                        end else if ((gate_rise || (load_pending && !running)) && have_count) begin
                            ce <= cr; out <= 1'b1; null_count <= 1'b0;
                            load_pending <= 1'b0; running <= 1'b1;
                        end else if (running) begin
                            if (ce == 16'd1) begin
                                ce <= cr; out <= 1'b1; null_count <= 1'b0; load_pending <= 1'b0;
                            end else begin
                                ce <= n1;
                                if (n1 == 16'd1) out <= 1'b0;
                            end
                        end
                    end
                    3'd3: begin
                        if (!gate) begin
                            out <= 1'b1;
                        end else if ((gate_rise || (load_pending && !running)) && have_count) begin
                            ce <= cr_even; extra <= cr[0]; out <= 1'b1; null_count <= 1'b0;
                            load_pending <= 1'b0; running <= 1'b1;
                        end else if (running) begin
                            if (ce == 16'd2) begin
                                if (extra) begin
                                    extra <= 1'b0;
                                end else begin
                                    // Odd counts get the extra clock in the high half only.
                                    ce <= cr_even; extra <= !out && cr[0]; out <= !out;
                                    null_count <= 1'b0; load_pending <= 1'b0;
                                end
                            end else begin
                                ce <= n2;
                            end
                        end
                    end
                    default: begin
                        out <= 1'b1;
                        if ((mode == 3'd4) ? load_pending : (gate_rise && have_count)) begin
                            ce <= cr; null_count <= 1'b0; load_pending <= 1'b0;
                            running <= 1'b1; armed <= 1'b1;
                        end else if (running && (gate || mode == 3'd5)) begin
                            ce <= n1;
                            if (n1 == 16'd0 && armed) begin
                                out <= 1'b0; armed <= 1'b0;
                            end
                        end
                    end
                endcase

                // Count register writes
                if (wr_en) begin
                    null_count <= 1'b1;
                    if (rw == 2'b11 && !wr_msb) begin
                        cr[7:0] <= Data;
                        wr_msb  <= 1'b1;
                        if (mode == 3'd0) begin
                            running <= 1'b0; load_pending <= 1'b0; out <= 1'b0;
                        end
                    end else begin
                        if (rw == 2'b01)      cr <= {8'h00, Data};
                        else if (rw == 2'b10) cr <= {Data, 8'h00};
                        else                  cr[15:8] <= Data;
                        wr_msb <= 1'b0;
                        have_count <= 1'b1;
                        load_pending <= 1'b1;
                        if (mode == 3'd0) out <= 1'b0;
                        if (mode == 3'd0 || mode == 3'd4) running <= 1'b0;
                    end
                end

                // Read completion frees latches
                if (rd_done) begin
                    if (status_full) begin
                        status_full <= 1'b0;
                    end else if (rw == 2'b11) begin
                        rd_msb <= !rd_msb;
                        if (rd_msb) ol_full <= 1'b0;
                    end else begin
                        ol_full <= 1'b0;
                    end
                end

                if (latch_cmd && !ol_full) begin
                    ol <= ce; ol_full <= 1'b1;
                end
                if (EnableStatusLatch && !status_full) begin
                    status <= {out, null_count, cw}; status_full <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pit_counter.sv
// tb/tb_pit_counter.sv - self-checking bench for pit_counter
module tb_pit_counter;

    logic        clk = 1'b0;
    logic        reset, WriteSignal, ReadSignal, gate;
    logic        EnableStatusLatch, EnableCounterLatch, ChgControlWord;
    logic [5:0]  ControlWord;
    logic        data_en;
    logic [7:0]  data_drv;
    wire  [7:0]  Data;
    logic        out;
    logic [15:0] CEoutput;

    int tests = 0;
    int fails = 0;
    logic [16:0] exp_q[$];

    assign Data = data_en ? data_drv : 8'hzz;

    always #5 clk = ~clk;

    pit_counter dut (
        .clkinput(clk), .reset(reset), .Data(Data), .out(out),
        .WriteSignal(WriteSignal), .ReadSignal(ReadSignal), .gate(gate),
        .EnableStatusLatch(EnableStatusLatch), .EnableCounterLatch(EnableCounterLatch),
        .ControlWord(ControlWord), .ChgControlWord(ChgControlWord), .CEoutput(CEoutput)
    );

    function automatic logic [15:0] bcd_dec_model(input logic [15:0] v);
        int d;
        logic [15:0] r;
        d = v[15:12] * 1000 + v[11:8] * 100 + v[7:4] * 10 + v[3:0];
        d = (d == 0) ? 9999 : d - 1;
        r[15:12] = 4'(d / 1000);
        r[11:8]  = 4'((d / 100) % 10);
        r[7:4]   = 4'((d / 10) % 10);
        r[3:0]   = 4'(d % 10);
        return r;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic write_cw(input logic [5:0] w);
        ControlWord = w; ChgControlWord = 1'b1;
        tick(1);
        ChgControlWord = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] b);
        data_drv = b; data_en = 1'b1; WriteSignal = 1'b1;
        tick(1);
        WriteSignal = 1'b0; data_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; WriteSignal = 1'b0; ReadSignal = 1'b0; gate = 1'b0;
        EnableStatusLatch = 1'b0; EnableCounterLatch = 1'b0; ChgControlWord = 1'b0;
        ControlWord = 6'd0; data_en = 1'b0; data_drv = 8'h00;
        tick(2);
        reset = 1'b0;
        tick(1);
        tests++; if (out !== 1'b0) begin fails++; $display("FAIL reset_out: got %b expected 0", out); end
        tests++; if (CEoutput !== 16'h0000) begin fails++; $display("FAIL reset_ce: got %h expected 0000", CEoutput); end
        data_drv = 8'h5A; data_en = 1'b1; #1;
        tests++; if (Data !== 8'h5A) begin fails++; $display("FAIL data_idle: got %h expected 5a", Data); end
        data_en = 1'b0;
    endtask

    task automatic test_mode1_bcd();
        logic [16:0] e;
        logic [15:0] v;
        logic        o;
        write_cw(6'b010011);
        tests++; if (out !== 1'b1) begin fails++; $display("FAIL m1_init_out: got %b expected 1", out); end
        write_byte(8'h10);
        gate = 1'b1;
        tick(1);
        tick(1);
        tests++; if ({out, CEoutput} !== {1'b0, 16'h0010}) begin
            fails++; $display("FAIL m1_load: got %b/%h expected 0/0010", out, CEoutput);
        end
        v = 16'h0010; o = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            v = bcd_dec_model(v);
            if (v == 16'h0000) o = 1'b1;
            exp_q.push_back({o, v});
        end
        for (int k = 1; k <= 13; k++) begin
            tick(1);
            e = exp_q.pop_front();
            tests++; if ({out, CEoutput} !== e) begin
                fails++; $display("FAIL m1_step%0d: got %b/%h expected %b/%h", k, out, CEoutput, e[16], e[15:0]);
            end
            if (k == 4) EnableCounterLatch = 1'b1;
            if (k == 5) begin EnableCounterLatch = 1'b0; ReadSignal = 1'b1; end
            if (k == 6) EnableCounterLatch = 1'b1;
            if (k == 7) EnableCounterLatch = 1'b0;
            if (k >= 5 && k <= 9) begin
                #1;
                tests++; if (Data !== 8'h06) begin fails++; $display("FAIL m1_latched_read%0d: got %h expected 06", k, Data); end
            end
            if (k == 9) ReadSignal = 1'b0;
            if (k == 10) ReadSignal = 1'b1;
            if (k == 11) begin
                #1;
                tests++; if (Data !== e[7:0]) begin fails++; $display("FAIL m1_ol_freed: got %h expected %h", Data, e[7:0]); end
                ReadSignal = 1'b0;
            end
        end
    endtask

    task automatic test_mode0();
        int n;
        logic [15:0] remain;
        write_cw(6'b110000);
        tests++; if (out !== 1'b0) begin fails++; $display("FAIL m0_init_out: got %b expected 0", out); end
        gate = 1'b1;
        write_byte(8'h34);
        write_byte(8'h12);
        tick(1);
        tests++; if ({out, CEoutput} !== {1'b0, 16'h1234}) begin
            fails++; $display("FAIL m0_load: got %b/%h expected 0/1234", out, CEoutput);
        end
        tick(100);
        remain = 16'h1234 - 16'd100;
        tests++; if ({out, CEoutput} !== {1'b0, remain}) begin
            fails++; $display("FAIL m0_count: got %b/%h expected 0/%h", out, CEoutput, remain);
        end
        gate = 1'b0;
        tick(5);
        tests++; if (CEoutput !== remain) begin fails++; $display("FAIL m0_gate_freeze: got %h expected %h", CEoutput, remain); end
        gate = 1'b1;
        n = 0;
        while (CEoutput != 16'h0000 && n < 6000) begin
            tick(1);
            n++;
        end
        tests++; if (n != int'(remain)) begin fails++; $display("FAIL m0_tc_clocks: got %0d expected %0d", n, remain); end
        tests++; if (out !== 1'b1) begin fails++; $display("FAIL m0_tc_out: got %b expected 1", out); end
        tick(1);
        tests++; if ({out, CEoutput} !== {1'b1, 16'hFFFF}) begin
            fails++; $display("FAIL m0_wrap: got %b/%h expected 1/ffff", out, CEoutput);
        end
    endtask

    task automatic test_status();
        write_cw(6'b010000);
        EnableStatusLatch = 1'b1; tick(1); EnableStatusLatch = 1'b0;
        ReadSignal = 1'b1; tick(1);
        tests++; if (Data !== 8'h50) begin fails++; $display("FAIL status_null1: got %h expected 50", Data); end
        ReadSignal = 1'b0; tick(1);
        write_byte(8'h08);
        tick(1);
        tests++; if (CEoutput !== 16'h0008) begin fails++; $display("FAIL status_load: got %h expected 0008", CEoutput); end
        EnableStatusLatch = 1'b1; tick(1); EnableStatusLatch = 1'b0;
        ReadSignal = 1'b1; tick(1);
        tests++; if (Data !== 8'h10) begin fails++; $display("FAIL status_null0: got %h expected 10", Data); end
        ReadSignal = 1'b0; tick(1);
    endtask

    task automatic test_mode3();
        logic [16:0] e;
        gate = 1'b1;
        write_cw(6'b010110);
        write_byte(8'd5);
        for (int i = 0; i < 20; i++) exp_q.push_back({16'd0, ((i % 5) < 3) ? 1'b1 : 1'b0});
        for (int i = 0; i < 20; i++) begin
            tick(1);
            e = exp_q.pop_front();
            tests++; if (out !== e[0]) begin fails++; $display("FAIL m3_out%0d: got %b expected %b", i, out, e[0]); end
        end
    endtask

    task automatic test_mode2();
        logic [16:0] e;
        gate = 1'b1;
        write_cw(6'b010100);
        write_byte(8'd4);
        for (int r = 0; r < 3; r++) begin
            exp_q.push_back({1'b1, 16'd4});
            exp_q.push_back({1'b1, 16'd3});
            exp_q.push_back({1'b1, 16'd2});
            exp_q.push_back({1'b0, 16'd1});
        end
        for (int i = 0; i < 12; i++) begin
            tick(1);
            e = exp_q.pop_front();
            tests++; if ({out, CEoutput} !== e) begin
                fails++; $display("FAIL m2_step%0d: got %b/%h expected %b/%h", i, out, CEoutput, e[16], e[15:0]);
            end
        end
        gate = 1'b0;
        tick(3);
        tests++; if ({out, CEoutput} !== {1'b1, 16'd1}) begin
            fails++; $display("FAIL m2_gate_low: got %b/%h expected 1/0001", out, CEoutput);
        end
    endtask

    task automatic test_back_to_back();
        ControlWord = 6'b010000; ChgControlWord = 1'b1;
        data_drv = 8'h33; data_en = 1'b1; WriteSignal = 1'b1;
        tick(1);
        ChgControlWord = 1'b0; WriteSignal = 1'b0; data_en = 1'b0;
        tests++; if (out !== 1'b0) begin fails++; $display("FAIL cw_wins_out: got %b expected 0", out); end
        tick(3);
        tests++; if (CEoutput !== 16'd1) begin fails++; $display("FAIL cw_wins_ce: got %h expected 0001", CEoutput); end
        write_byte(8'h33);
        tick(1);
        tests++; if (CEoutput !== 16'h0033) begin fails++; $display("FAIL cw_then_write: got %h expected 0033", CEoutput); end
    endtask

    initial begin
        test_reset();
        test_mode1_bcd();
        test_mode0();
        test_status();
        test_mode3();
        test_mode2();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
